// File: rtl/layer_sequencer_pkg.sv
// Shared constants for the layer sequencer: FSM state encoding and default field widths.
package layer_sequencer_pkg;

  localparam int DIM_W_DEF = 8;
  localparam int CNT_W_DEF = 2 * DIM_W_DEF;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

endpackage

// File: rtl/layer_cfg_table.sv
// Per-layer frame dimensions: one write port, one asynchronous read port,
// cleared on reset. Reads beyond the populated range return an empty layer.
module layer_cfg_table
  import layer_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int DIM_W      = DIM_W_DEF,
  parameter int AW         = $clog2(NUM_LAYERS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DIM_W-1:0] wr_width,
  input  logic [DIM_W-1:0] wr_height,
  input  logic [AW-1:0]    raddr,
  output logic [DIM_W-1:0] rd_width,
  output logic [DIM_W-1:0] rd_height
);

  logic [2*DIM_W-1:0] entry [NUM_LAYERS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        entry[i] <= '0;
      end
    end else if (we && (int'(waddr) < NUM_LAYERS)) begin
      entry[waddr] <= {wr_width, wr_height};
    end
  end

  always_comb begin
    {rd_width, rd_height} = '0;
    if (int'(raddr) < NUM_LAYERS) begin
      {rd_width, rd_height} = entry[raddr];
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Walks the layer table, launching the conv engine once per non-empty layer and
// framing its pixel stream with sof/eof plus per-layer and end-of-table pulses.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter  int NUM_LAYERS = 4,
  parameter  int DIM_W      = DIM_W_DEF,
  localparam int CNT_W      = 2 * DIM_W,
  localparam int AW         = $clog2(NUM_LAYERS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  output logic             eng_start,
  output logic [DIM_W-1:0] eng_width,
  output logic [DIM_W-1:0] eng_height,
  input  logic             eng_valid,
  output logic             sof,
  output logic             eof,
  output logic [AW-1:0]    layer_idx,
  output logic [CNT_W-1:0] pixel_cnt,
  output logic             layer_done,
  output logic             done,
  output logic             busy,
  output logic             err
);

  state_t           state;
  logic [AW-1:0]    rd_addr;
  logic [DIM_W-1:0] tbl_width;
  logic [DIM_W-1:0] tbl_height;
  logic [CNT_W-1:0] frame_area;
  logic             tbl_we;
  logic             tbl_empty;
  logic             in_frame;
  logic             pix_acc;
  logic             last_pix;
  logic             last_layer;

  // The read port only matters when choosing the next layer to load:
  // entry 0 on start, entry layer_idx+1 at a layer boundary.
  assign rd_addr = (state == S_IDLE) ? '0 : layer_idx + AW'(1);
  assign tbl_we  = cfg_we && (state == S_IDLE);

  layer_cfg_table #(
    .NUM_LAYERS (NUM_LAYERS),
    .DIM_W      (DIM_W),
    .AW         (AW)
  ) u_cfg_table (
    .clk       (clk),
    .resetn    (resetn),
    .we        (tbl_we),
    .waddr     (cfg_addr),
    .wr_width  (cfg_width),
    .wr_height (cfg_height),
    .raddr     (rd_addr),
    .rd_width  (tbl_width),
    .rd_height (tbl_height)
  );

  assign tbl_empty  = (tbl_width == '0) || (tbl_height == '0);
  assign frame_area = CNT_W'(eng_width) * CNT_W'(eng_height);
  assign in_frame   = (state == S_LAUNCH) || (state == S_RUN);
  assign pix_acc    = in_frame && eng_valid;
  assign last_pix   = pix_acc && (pixel_cnt == frame_area - CNT_W'(1));
  assign last_layer = (layer_idx == AW'(NUM_LAYERS - 1));

  assign eng_start  = (state == S_LAUNCH);
  assign layer_done = (state == S_NEXT);
  assign done       = (state == S_FIN);
  assign busy       = (state != S_IDLE);
  assign sof        = pix_acc && (pixel_cnt == '0);
  assign eof        = last_pix;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      layer_idx  <= '0;
      pixel_cnt  <= '0;
      eng_width  <= '0;
      eng_height <= '0;
      err        <= 1'b0;
    end else begin
      if ((cfg_we && busy) || (eng_valid && !in_frame)) begin
        err <= 1'b1;
      end
      if (pix_acc) begin
        pixel_cnt <= pixel_cnt + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            layer_idx  <= '0;
            eng_width  <= tbl_width;
            eng_height <= tbl_height;
            state      <= tbl_empty ? S_NEXT : S_LAUNCH;
          end
        end
        S_LAUNCH, S_RUN: begin
          state <= last_pix ? S_NEXT : S_RUN;
        end
        S_NEXT: begin
          pixel_cnt <= '0;
          if (last_layer) begin
            state <= S_FIN;
          end else begin
            // Empty layers go straight to another boundary, never launching.
            layer_idx  <= layer_idx + AW'(1);
            eng_width  <= tbl_width;
            eng_height <= tbl_height;
            state      <= tbl_empty ? S_NEXT : S_LAUNCH;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer: an abstract phase/position model of the
// sequencer is compared against the DUT every cycle, plus literal scenario checks.
module tb_layer_sequencer;

  localparam int NL = 3;
  localparam int DW = 8;
  localparam int CW = 2 * DW;
  localparam int AW = $clog2(NL);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_width = '0;
  logic [DW-1:0] cfg_height = '0;
  logic          eng_valid = 1'b0;
  logic          eng_start, sof, eof, layer_done, done, busy, err;
  logic [DW-1:0] eng_width, eng_height;
  logic [AW-1:0] layer_idx;
  logic [CW-1:0] pixel_cnt;

  layer_sequencer #(.NUM_LAYERS(NL), .DIM_W(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .eng_start  (eng_start),
    .eng_width  (eng_width),
    .eng_height (eng_height),
    .eng_valid  (eng_valid),
    .sof        (sof),
    .eof        (eof),
    .layer_idx  (layer_idx),
    .pixel_cnt  (pixel_cnt),
    .layer_done (layer_done),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int cur_idx = 0;
  int es_q[$], esw_q[$], esh_q[$], sof_q[$], eof_q[$];
  int ld_cnt = 0, done_cnt = 0, done_cyc = -1, max_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Model: phase 0 idle, 1 launch, 2 streaming, 3 layer boundary, 4 finish.
  int m_ph = 0, m_lay = 0, m_cnt = 0;
  bit m_err = 1'b0;
  int m_w[NL], m_h[NL];

  function automatic int area(input int l);
    return m_w[l] * m_h[l];
  endfunction

  function automatic int enter(input int l);
    return (area(l) == 0) ? 3 : 1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ph <= 0; m_lay <= 0; m_cnt <= 0; m_err <= 1'b0;
      foreach (m_w[i]) begin m_w[i] <= 0; m_h[i] <= 0; end
    end else begin
      if (cfg_we && m_ph != 0) m_err <= 1'b1;
      if (eng_valid && !(m_ph == 1 || m_ph == 2)) m_err <= 1'b1;
      case (m_ph)
        0: begin
          if (cfg_we && int'(cfg_addr) < NL) begin
            m_w[cfg_addr] <= int'(cfg_width);
            m_h[cfg_addr] <= int'(cfg_height);
          end
          if (start) begin m_lay <= 0; m_ph <= enter(0); end
        end
        1, 2: begin
          if (eng_valid) m_cnt <= m_cnt + 1;
          m_ph <= (eng_valid && m_cnt + 1 == area(m_lay)) ? 3 : 2;
        end
        3: begin
          m_cnt <= 0;
          if (m_lay == NL - 1) m_ph <= 4;
          else begin m_lay <= m_lay + 1; m_ph <= enter(m_lay + 1); end
        end
        default: m_ph <= 0;
      endcase
    end
  end

  // Per-cycle compare plus event capture for the literal scenario checks.
  bit in_frm;
  always @(negedge clk) begin
    in_frm = (m_ph == 1 || m_ph == 2);
    chk("busy", busy, m_ph != 0);
    chk("eng_start", eng_start, m_ph == 1);
    chk("layer_done", layer_done, m_ph == 3);
    chk("done", done, m_ph == 4);
    chk("err", err, m_err);
    chk("layer_idx", layer_idx, m_lay);
    chk("pixel_cnt", pixel_cnt, m_cnt);
    chk("sof", sof, in_frm && eng_valid && m_cnt == 0);
    chk("eof", eof, in_frm && eng_valid && m_cnt == area(m_lay) - 1);
    if (in_frm) begin
      chk("eng_width", eng_width, m_w[m_lay]);
      chk("eng_height", eng_height, m_h[m_lay]);
    end
    if (eng_start) begin
      es_q.push_back(cyc - t0);
      esw_q.push_back(int'(eng_width));
      esh_q.push_back(int'(eng_height));
    end
    if (sof) sof_q.push_back(cur_idx);
    if (eof) eof_q.push_back(cur_idx);
    if (layer_done) ld_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc - t0; end
    if (int'(pixel_cnt) > max_cnt) max_cnt = int'(pixel_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int w, input int h);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_width = DW'(w); cfg_height = DW'(h);
    step();
    cfg_we = 1'b0;
  endtask

  // Starts the table and plays the engine: after each eng_start it emits W*H
  // valids with ~pct% density. Optional cfg_we injection and mid-layer reset.
  task automatic run_seq(input int pct, input int budget, input int inj_k, input int abort_n);
    int pending, issued;
    bit ended;
    pending = 0; issued = 0; ended = 1'b0;
    es_q.delete(); esw_q.delete(); esh_q.delete(); sof_q.delete(); eof_q.delete();
    ld_cnt = 0; done_cnt = 0; done_cyc = -1; max_cnt = 0;
    start = 1'b1; t0 = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (abort_n >= 0 && issued == abort_n) begin
        eng_valid = 1'b0;
        chk("rst_pre_cnt", pixel_cnt, abort_n);
        #2 resetn = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_layer_done", layer_done, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_layer_idx", layer_idx, 0);
        chk("rst_pixel_cnt", pixel_cnt, 0);
        chk("rst_eng_width", eng_width, 0);
        chk("rst_sof_eof", {sof, eof}, 0);
        return;
      end
      eng_valid = 1'b0;
      cfg_we = (k == inj_k);
      if (k == inj_k) begin cfg_addr = '0; cfg_width = DW'(9); cfg_height = DW'(9); end
      if (!busy) begin ended = 1'b1; break; end
      if (eng_start) begin
        pending = area(m_lay);
        issued = 0;
      end else if (pending > 0 && $urandom_range(99) < pct) begin
        eng_valid = 1'b1; cur_idx = issued; issued++; pending--;
      end
      step();
    end
    cfg_we = 1'b0; eng_valid = 1'b0;
    chk("seq_ended", ended, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    chk("reset_busy", busy, 0);
    chk("reset_cnt", pixel_cnt, 0);
    chk("reset_idx", layer_idx, 0);
    chk("reset_err", err, 0);
    step(); step();
    resetn = 1'b1;
    step();

    // Two framed layers, then a short third one.
    wr(0, 4, 4); wr(1, 2, 3); wr(2, 3, 1);
    run_seq(100, 2000, -1, -1);
    chk("l038_es0", qat(es_q, 0), 1);
    chk("l038_es1", qat(es_q, 1), 19);
    chk("l038_es2", qat(es_q, 2), 27);
    chk("l038_sof_n", sof_q.size(), 3);
    chk("l038_eof0", qat(eof_q, 0), 15);
    chk("l038_eof1", qat(eof_q, 1), 5);
    chk("l038_eof2", qat(eof_q, 2), 2);
    chk("l038_ld", ld_cnt, 3);
    chk("l038_done", done_cnt, 1);

    // Empty middle layer is skipped without a launch.
    wr(0, 2, 2); wr(1, 0, 5); wr(2, 3, 2);
    run_seq(100, 2000, -1, -1);
    chk("l039_es_n", es_q.size(), 2);
    chk("l039_es1", qat(es_q, 1), 8);
    chk("l039_ld", ld_cnt, 3);
    chk("l039_done_cyc", done_cyc, 16);

    for (int r = 0; r < 4; r++) begin
      for (int l = 0; l < NL; l++) wr(l, $urandom_range(0, 5), $urandom_range(0, 5));
      run_seq($urandom_range(30, 100), 3000, -1, -1);
    end

    // Protocol errors: valid while idle, table write while running.
    eng_valid = 1'b1;
    step();
    eng_valid = 1'b0;
    chk("l040_err_idle", err, 1);
    chk("l040_cnt_idle", pixel_cnt, 0);
    wr(0, 1, 3); wr(1, 2, 2); wr(2, 1, 1);
    run_seq(100, 2000, 2, -1);
    chk("l040_err_sticky", err, 1);
    run_seq(100, 2000, -1, -1);
    chk("l040_tbl_w", qat(esw_q, 0), 1);
    chk("l040_tbl_h", qat(esh_q, 0), 3);
    chk("l040_err_end", err, 1);

    // Reset mid-layer, then confirm the table cleared and a clean rerun.
    wr(0, 4, 4);
    run_seq(100, 2000, -1, 8);
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("l041_no_pulse", {layer_done, done, busy}, 0);
    end
    run_seq(100, 2000, -1, -1);
    chk("l041_zero_tbl_es", es_q.size(), 0);
    chk("l041_zero_tbl_ld", ld_cnt, 3);
    chk("l041_zero_tbl_done", done_cnt, 1);
    wr(0, 4, 4); wr(1, 1, 2); wr(2, 2, 1);
    run_seq(100, 2000, -1, -1);
    chk("l041_rerun_es0", qat(es_q, 0), 1);
    chk("l041_rerun_eof0", qat(eof_q, 0), 15);

    // Large frame with gapped valids: counter must reach W*H without wrapping.
    wr(0, 224, 224); wr(1, 1, 1); wr(2, 0, 0);
    run_seq(80, 80000, -1, -1);
    chk("l042_eof_n", eof_q.size(), 2);
    chk("l042_eof0", qat(eof_q, 0), 50175);
    chk("l042_max_cnt", max_cnt, 50176);
    chk("l042_done", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
